// File: rtl/rmii_mac_pkg.sv
`default_nettype none
// Types and constants shared by the RMII MAC transmitter and receiver.
package rmii_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_FCS      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0]  SFD_LAST_DIBIT  = 2'b11;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam int DEFAULT_IFG_DIBITS      = 48;
  localparam int DEFAULT_PREAMBLE_DIBITS = 28;
  localparam int SFD_DIBITS              = 4;
  localparam int FCS_DIBITS              = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32_d2.sv
`default_nettype none
// Next-state of the reflected Ethernet CRC-32 after one dibit (bit 0 first).
module eth_crc32_d2
  import rmii_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [1:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 2; i++) begin
      if (crc_out[0] ^ data[i])
        crc_out = (crc_out >> 1) ^ CRC32_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rmii_mac_tx.sv
`default_nettype none
// RMII MAC transmitter: frames a 2-bit AXI stream with preamble/SFD, optional
// FCS, and enforces the inter-frame gap. txd/txen are registered.
module rmii_mac_tx
  import rmii_mac_pkg::*;
#(
  parameter bit APPEND_FCS      = 1'b1,
  parameter int IFG_DIBITS      = DEFAULT_IFG_DIBITS,
  parameter int PREAMBLE_DIBITS = DEFAULT_PREAMBLE_DIBITS
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       axi_tvalid,
  output logic       axi_tready,
  input  logic [1:0] axi_tdata,
  input  logic       axi_tlast,
  input  logic       axi_tuser,
  output logic [1:0] txd,
  output logic       txen,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int CNT_MAX = max3(IFG_DIBITS, PREAMBLE_DIBITS, FCS_DIBITS);
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_DIBITS - 1);
  localparam logic [CNT_W-1:0] SFD_LAST = CNT_W'(SFD_DIBITS - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_DIBITS - 1);
  // The IDLE cycle that follows IFG is the final cycle of the gap.
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_DIBITS - 2);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      crc;
  logic [31:0]      crc_next;

  logic [1:0]       txd_d;
  logic             txen_d;
  logic             done_d;
  logic             abort_d;
  logic             crc_step;
  logic             counting;

  eth_crc32_d2 u_crc (
    .crc_in  (crc),
    .data    (axi_tdata),
    .crc_out (crc_next)
  );

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:     if (axi_tvalid) state_next = ST_PREAMBLE;
      ST_PREAMBLE: if (cnt == PRE_LAST) state_next = ST_SFD;
      ST_SFD:      if (cnt == SFD_LAST) state_next = ST_DATA;
      ST_DATA: begin
        if (!axi_tvalid)
          state_next = ST_DRAIN;
        else if (axi_tuser)
          state_next = axi_tlast ? ST_IFG : ST_DRAIN;
        else if (axi_tlast)
          state_next = APPEND_FCS ? ST_FCS : ST_IFG;
      end
      ST_FCS:      if (cnt == FCS_LAST) state_next = ST_IFG;
      ST_DRAIN:    if (axi_tvalid && axi_tlast) state_next = ST_IFG;
      ST_IFG:      if (cnt == IFG_LAST) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    txd_d      = 2'b00;
    txen_d     = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    axi_tready = 1'b0;
    crc_step   = 1'b0;
    unique case (state)
      ST_PREAMBLE: begin
        txd_d  = PREAMBLE_DIBIT;
        txen_d = 1'b1;
      end
      ST_SFD: begin
        txd_d  = (cnt == SFD_LAST) ? SFD_LAST_DIBIT : PREAMBLE_DIBIT;
        txen_d = 1'b1;
      end
      ST_DATA: begin
        axi_tready = 1'b1;
        if (axi_tvalid && !axi_tuser) begin
          txd_d    = axi_tdata;
          txen_d   = 1'b1;
          crc_step = 1'b1;
          done_d   = axi_tlast && !APPEND_FCS;
        end else begin
          abort_d  = 1'b1;
        end
      end
      ST_FCS: begin
        txd_d  = ~crc[1:0];
        txen_d = 1'b1;
        done_d = (cnt == FCS_LAST);
      end
      ST_DRAIN:    axi_tready = 1'b1;
      default:     ;
    endcase
  end

  assign counting = (state == ST_PREAMBLE) || (state == ST_SFD) ||
                    (state == ST_FCS) || (state == ST_IFG);

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      cnt      <= '0;
      crc      <= '0;
      txd      <= 2'b00;
      txen     <= 1'b0;
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
    end else begin
      txd      <= txd_d;
      txen     <= txen_d;
      tx_done  <= done_d;
      tx_abort <= abort_d;

      if (!counting || (state_next != state))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      // The FCS is emitted by shifting the finished CRC out two bits at a time.
      if (state == ST_SFD)
        crc <= CRC32_INIT;
      else if (crc_step)
        crc <= crc_next;
      else if (state == ST_FCS)
        crc <= {2'b00, crc[31:2]};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmii_mac_tx.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for rmii_mac_tx: FCS-appending and raw instances.
module tb_rmii_mac_tx;

  logic       clock = 1'b0;
  logic       arst_n;
  logic [1:0] tdata;
  logic       tlast, tuser;
  logic       v0, v1;
  logic       rdy0, rdy1;
  logic [1:0] txd0, txd1;
  logic       txen0, txen1, done0, done1, abort0, abort1;

  always #10 clock = ~clock;

  rmii_mac_tx #(.APPEND_FCS(1'b1)) dut0 (
    .clock(clock), .arst_n(arst_n),
    .axi_tvalid(v0), .axi_tready(rdy0), .axi_tdata(tdata),
    .axi_tlast(tlast), .axi_tuser(tuser),
    .txd(txd0), .txen(txen0), .tx_done(done0), .tx_abort(abort0)
  );

  rmii_mac_tx #(.APPEND_FCS(1'b0)) dut1 (
    .clock(clock), .arst_n(arst_n),
    .axi_tvalid(v1), .axi_tready(rdy1), .axi_tdata(tdata),
    .axi_tlast(tlast), .axi_tuser(tuser),
    .txd(txd1), .txen(txen1), .tx_done(done1), .tx_abort(abort1)
  );

  typedef struct packed {
    logic       txen;
    logic [1:0] txd;
    logic       done;
    logic       abort;
  } samp_t;

  typedef struct {
    int          nbytes;
    logic [71:0] msg;
    logic [31:0] crc;
    int          exp_high;
  } vec_t;

  samp_t      cap[$];
  logic [7:0] fb[$];
  bit         mon_en = 1'b0;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (sel == 0) cap.push_back({txen0, txd0, done0, abort0});
      else          cap.push_back({txen1, txd1, done1, abort1});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic samp_t at(input int i);
    if (i >= 0 && i < cap.size()) return cap[i];
    return '0;
  endfunction

  task automatic set_valid(input int s, input logic b);
    if (s == 0) v0 = b; else v1 = b;
  endtask

  task automatic load_msg(input int n, input logic [71:0] msg);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(msg[8*(n-1-i) +: 8]);
  endtask

  task automatic load_count(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'((i * 37 + 11) & 255));
  endtask

  // Streams fb; a one-cycle tvalid gap before dibit gap_at, tuser on dibit user_at.
  task automatic drive_frame(input int s, input int gap_at, input int user_at);
    int  n;
    int  idx;
    int  cyc;
    bit  gapped;
    bit  do_gap;
    logic r;
    n = fb.size() * 4; idx = 0; cyc = 0; gapped = 1'b0;
    while (idx < n && cyc < 3000) begin
      do_gap = (idx == gap_at) && !gapped;
      set_valid(s, !do_gap);
      tdata = fb[idx/4][2*(idx%4) +: 2];
      tlast = (idx == n - 1);
      tuser = (idx == user_at);
      @(negedge clock);
      r = (s == 0) ? rdy0 : rdy1;
      @(posedge clock); #1;
      if (r) begin
        if (do_gap) gapped = 1'b1;
        else idx++;
      end
      cyc++;
    end
    chk("drive_beats_accepted", 32'(idx), 32'(n));
    set_valid(s, 1'b0);
    tlast = 1'b0;
    tuser = 1'b0;
  endtask

  task automatic find_run(input int from, output int st, output int ln);
    st = -1; ln = 0;
    for (int i = from; i < cap.size(); i++) begin
      if (cap[i].txen) begin st = i; break; end
    end
    if (st >= 0)
      for (int i = st; i < cap.size() && cap[i].txen; i++) ln++;
  endtask

  task automatic count_pulses(output int nd, output int na);
    nd = 0; na = 0;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i].done)  nd++;
      if (cap[i].abort) na++;
    end
  endtask

  task automatic check_frame(input string nm, input int st, input bit fcs, input logic [31:0] crc);
    int         n;
    int         bad;
    int         last;
    logic [7:0] sfd;
    logic [31:0] f;
    n = fb.size() * 4;
    bad = 0;
    for (int i = 0; i < 28; i++) if (at(st + i).txd != 2'b01) bad++;
    chk({nm, "_preamble_bad"}, 32'(bad), 32'd0);
    for (int k = 0; k < 4; k++) sfd[2*k +: 2] = at(st + 28 + k).txd;
    chk({nm, "_sfd"}, 32'(sfd), 32'hD5);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (at(st + 32 + i).txd != fb[i/4][2*(i%4) +: 2]) bad++;
    chk({nm, "_data_bad"}, 32'(bad), 32'd0);
    if (fcs) begin
      f = '0;
      for (int k = 0; k < 16; k++) f[2*k +: 2] = at(st + 32 + n + k).txd;
      chk({nm, "_fcs"}, f, crc);
    end
    last = st + 32 + n + (fcs ? 16 : 0) - 1;
    chk({nm, "_done_on_last"}, 32'(at(last).done), 32'd1);
  endtask

  vec_t vec[3];
  int   st, ln, st2, ln2, nd, na, lowcnt;

  initial begin
    vec[0] = '{9, "123456789", 32'hCBF43926, 84};
    vec[1] = '{1, "a",         32'hE8B7BE43, 52};
    vec[2] = '{3, "abc",       32'h352441C2, 60};

    arst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
    tdata = 2'b00; tlast = 1'b0; tuser = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("reset_txen",   32'(txen0),  32'd0);
    chk("reset_txd",    32'(txd0),   32'd0);
    chk("reset_tready", 32'(rdy0),   32'd0);
    chk("reset_done",   32'(done0),  32'd0);
    chk("reset_abort",  32'(abort0), 32'd0);
    arst_n = 1'b1;
    @(posedge clock); #1;
    chk("idle_tready", 32'(rdy0), 32'd0);

    for (int t = 0; t < 3; t++) begin
      load_msg(vec[t].nbytes, vec[t].msg);
      cap.delete(); sel = 0; mon_en = 1'b1;
      drive_frame(0, -1, -1);
      repeat (60) @(posedge clock); #1;
      mon_en = 1'b0;
      find_run(0, st, ln);
      chk($sformatf("vec%0d_txen_len", t), 32'(ln), 32'(vec[t].exp_high));
      if (ln == vec[t].exp_high) check_frame($sformatf("vec%0d", t), st, 1'b1, vec[t].crc);
      count_pulses(nd, na);
      chk($sformatf("vec%0d_done_count", t), 32'(nd), 32'd1);
      chk($sformatf("vec%0d_abort_count", t), 32'(na), 32'd0);
    end

    // Back-to-back frames with tvalid never dropping.
    load_msg(9, "123456789");
    cap.delete(); sel = 0; mon_en = 1'b1;
    drive_frame(0, -1, -1);
    drive_frame(0, -1, -1);
    repeat (120) @(posedge clock); #1;
    mon_en = 1'b0;
    find_run(0, st, ln);
    find_run(st + ln, st2, ln2);
    chk("b2b_len1", 32'(ln), 32'd84);
    chk("b2b_gap", 32'(st2 - (st + ln)), 32'd48);
    chk("b2b_len2", 32'(ln2), 32'd84);
    if (ln2 == 84) check_frame("b2b_second", st2, 1'b1, 32'hCBF43926);
    count_pulses(nd, na);
    chk("b2b_done_count", 32'(nd), 32'd2);

    // Underrun at dibit 40, then an immediate follow-on frame.
    load_count(64);
    cap.delete(); sel = 0; mon_en = 1'b1;
    drive_frame(0, 40, -1);
    drive_frame(0, -1, -1);
    repeat (400) @(posedge clock); #1;
    mon_en = 1'b0;
    find_run(0, st, ln);
    find_run(st + ln, st2, ln2);
    chk("underrun_len", 32'(ln), 32'd72);
    chk("underrun_abort_at_fall", 32'(at(st + ln).abort), 32'd1);
    chk("underrun_gap_ge_48", 32'((st2 - (st + ln)) >= 48), 32'd1);
    chk("underrun_next_len", 32'(ln2), 32'd304);
    count_pulses(nd, na);
    chk("underrun_done_count", 32'(nd), 32'd1);
    chk("underrun_abort_count", 32'(na), 32'd1);

    // tuser on dibit 100 of a 256-dibit frame.
    load_count(64);
    cap.delete(); sel = 0; mon_en = 1'b1;
    drive_frame(0, -1, 100);
    repeat (80) @(posedge clock); #1;
    mon_en = 1'b0;
    find_run(0, st, ln);
    chk("tuser_len", 32'(ln), 32'd132);
    chk("tuser_abort_at_fall", 32'(at(st + ln).abort), 32'd1);
    count_pulses(nd, na);
    chk("tuser_done_count", 32'(nd), 32'd0);
    chk("tuser_abort_count", 32'(na), 32'd1);

    // Raw instance: no FCS, 60-byte frame.
    load_count(60);
    cap.delete(); sel = 1; mon_en = 1'b1;
    drive_frame(1, -1, -1);
    repeat (80) @(posedge clock); #1;
    mon_en = 1'b0;
    find_run(0, st, ln);
    chk("nofcs_len", 32'(ln), 32'd272);
    if (ln == 272) check_frame("nofcs", st, 1'b0, 32'd0);
    count_pulses(nd, na);
    chk("nofcs_done_count", 32'(nd), 32'd1);

    // Asynchronous reset in the middle of DATA.
    sel = 0;
    v0 = 1'b1; tdata = 2'b10; tlast = 1'b0; tuser = 1'b0;
    repeat (45) @(posedge clock);
    @(negedge clock);
    chk("pre_reset_txen", 32'(txen0), 32'd1);
    chk("pre_reset_txd",  32'(txd0),  32'd2);
    #3 arst_n = 1'b0;
    #1;
    chk("async_reset_txen", 32'(txen0), 32'd0);
    chk("async_reset_txd",  32'(txd0),  32'd0);
    v0 = 1'b0;
    repeat (2) @(posedge clock); #1;
    arst_n = 1'b1;
    lowcnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (!rdy0 && !txen0) lowcnt++;
    end
    chk("post_reset_quiet_cycles", 32'(lowcnt), 32'd5);
    load_msg(9, "123456789");
    cap.delete(); mon_en = 1'b1;
    drive_frame(0, -1, -1);
    repeat (60) @(posedge clock); #1;
    mon_en = 1'b0;
    find_run(0, st, ln);
    chk("post_reset_len", 32'(ln), 32'd84);
    if (ln == 84) check_frame("post_reset", st, 1'b1, 32'hCBF43926);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
